mult_arbiter: RTL
=================

Name: mult_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 16x16 shift-add multiplier between two requesters, e.g. the ALU MULT path and an address-scaling unit.
- Latches the granted requester's operands and holds them stable for the whole operation.
- Pulses the multiplier's start input, waits for its completion flag, then returns the 32-bit product to the owner with a one-cycle acknowledge.

Parameters:
- WIDTH, 16: operand width; the product is 2*WIDTH.
- TIMEOUT, 63: watchdog limit in cycles. Used only when MULT_ARB_TIMEOUT_EN is defined.

Ports:
- Clk  in  1  system clock; all logic is on the rising edge.
- Reset  in  1  synchronous, active-low reset. Reset=0 at a rising edge resets the block.
- Req0  in  1  requester 0 request. Held high until Ack0.
- A0, B0  in  WIDTH each  requester 0 multiplicand and multiplier.
- Req1  in  1  requester 1 request. Held high until Ack1.
- A1, B1  in  WIDTH each  requester 1 multiplicand and multiplier.
- Ack0, Ack1  out  1  one-cycle completion pulse to the owning requester.
- Result  out  2*WIDTH  registered product, valid while Ack0 or Ack1 is high and held afterwards.
- Err  out  1  watchdog abort flag, pulsed together with Ack. Tied to 0 when the feature is off.
- Busy  out  1  high in every state except IDLE.
- St  out  1  start pulse to the multiplier.
- Multiplicando, Multiplicador  out  WIDTH each  registered operands driven to the multiplier.
- Idle, Done  in  1 each  status inputs from the multiplier.
- Produto  in  2*WIDTH  product from the multiplier.

Behaviour:
- Reset (Reset=0 at an edge) gives: state=IDLE, St=0, Ack0=Ack1=0, Err=0, Busy=0, Result=0, operands=0, priority pointer=0 (requester 0 favoured).
- Reset mid-operation: the block returns to IDLE immediately and no Ack is issued. The multiplier is reset by the system in the same cycle.
- FSM states and transitions:
  - IDLE: waits for Req0 or Req1. With both high, the requester named by the pointer wins. On a grant, latch Ax/Bx into Multiplicando/Multiplicador, record the owner, go to WAIT_IDLE.
  - WAIT_IDLE: if Idle=1, assert St for exactly one cycle and go to RUN. Otherwise stay.
  - RUN: St=0. When Done=1, latch Produto into Result and go to ACK.
  - ACK: pulse the owner's Ack for one cycle. Pointer becomes the non-owner. Go to IDLE.
- Latency: grant to St is 1 cycle (when Idle is already 1). Done to Ack is 1 cycle. The earliest re-grant is the cycle after Ack.
- Operand stability: Multiplicando and Multiplicador change only on a grant in IDLE, never while in WAIT_IDLE, RUN or ACK. The multiplier's adder reads Multiplicando continuously, so this is mandatory.
- A requester whose Req drops before its Ack is still served. Its Ack is still pulsed and may be ignored.
- Req held high after Ack is treated as a new request. Fairness is guaranteed by the pointer: with both requesting continuously, grants alternate 0,1,0,1.
- Done seen while in IDLE or WAIT_IDLE is ignored.
- Only the owner's Ack may pulse. Ack0 and Ack1 are never high together.
- Result is stable from the ACK cycle until the next ACK.

Optional Feature:
- Macro: MULT_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to RUN and increments each RUN cycle.
  - If it reaches TIMEOUT without Done, go to ACK with Err=1 and Result=0.
  - In the same abort cycle, St is not reissued. The system must reset the multiplier.
  - The counter width is sized by $clog2(TIMEOUT+1).
- Undefined: there is no counter, RUN waits for Done indefinitely, and Err is constant 0.

Test Plan:
- Single request: Reset released, Req0=1, A0=16'd300, B0=16'd7, multiplier model Idle=1. Expect St in the cycle after grant, Ack0 one cycle after Done, Result=32'd2100, Ack1 never high.
- Simultaneous requests: Req0=Req1=1 in the same cycle, A0=3, B0=5, A1=16'hFFFF, B1=16'hFFFF. Expect requester 0 served first (Result=15), then requester 1 (Result=32'hFFFE0001). Repeating twice gives grant order 0,1,0,1.
- Operand hold: change A0/B0 every cycle during RUN. Multiplicando and Multiplicador stay at the latched values and Result is the product of the latched values.
- Busy multiplier: hold Idle=0 for 10 cycles after grant. St stays low until Idle rises, then exactly one St pulse.
- Reset mid-run: drive Reset=0 for one cycle while in RUN. Next cycle Busy=0, no Ack, pointer=0, and a new Req1 is granted normally.
- Watchdog (MULT_ARB_TIMEOUT_EN, TIMEOUT=20): Done never asserted. Exactly 20 cycles after entering RUN, Ack0=1 with Err=1 and Result=0, then return to IDLE.

Source files
------------

// File: rtl/mult_arbiter.sv
// Round-robin arbiter/sequencer sharing one shift-add multiplier between two requesters.
// Optional watchdog abort is compiled in when MULT_ARB_TIMEOUT_EN is defined.
module mult_arbiter #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 63
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Req0,
    input  logic [WIDTH-1:0]   A0,
    input  logic [WIDTH-1:0]   B0,
    input  logic               Req1,
    input  logic [WIDTH-1:0]   A1,
    input  logic [WIDTH-1:0]   B1,
    output logic               Ack0,
    output logic               Ack1,
    output logic [2*WIDTH-1:0] Result,
    output logic               Err,
    output logic               Busy,
    output logic               St,
    output logic [WIDTH-1:0]   Multiplicando,
    output logic [WIDTH-1:0]   Multiplicador,
    input  logic               Idle,
    input  logic               Done,
    input  logic [2*WIDTH-1:0] Produto,
    output logic [1:0]         dbg_state,
    output logic               dbg_ptr
);

    // Handshake: ReqN is a level held until AckN; AckN is a one-cycle pulse to the
    // owner only, and a ReqN still high after its AckN counts as a new request.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_IDLE = 2'd1,
        RUN       = 2'd2,
        ACK       = 2'd3
    } state_t;

    state_t             state, state_nx;
    logic               owner, owner_nx;
    logic               ptr, ptr_nx;
    logic               grant1;
    logic [WIDTH-1:0]   mcand_nx, mplier_nx;
    logic [2*WIDTH-1:0] result_nx;

`ifdef MULT_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] wd_cnt, wd_cnt_nx;
    logic          abort, abort_nx;
`else
    localparam int unused_timeout = TIMEOUT;
`endif

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state         <= IDLE;
            owner         <= 1'b0;
            ptr           <= 1'b0;
            Multiplicando <= '0;
            Multiplicador <= '0;
            Result        <= '0;
`ifdef MULT_ARB_TIMEOUT_EN
            wd_cnt        <= '0;
            abort         <= 1'b0;
`endif
        end else begin
            state         <= state_nx;
            owner         <= owner_nx;
            ptr           <= ptr_nx;
            Multiplicando <= mcand_nx;
            Multiplicador <= mplier_nx;
            Result        <= result_nx;
`ifdef MULT_ARB_TIMEOUT_EN
            wd_cnt        <= wd_cnt_nx;
            abort         <= abort_nx;
`endif
        end
    end

    always_comb begin
        state_nx  = state;
        owner_nx  = owner;
        ptr_nx    = ptr;
        mcand_nx  = Multiplicando;
        mplier_nx = Multiplicador;
        result_nx = Result;
        grant1    = 1'b0;
        St        = 1'b0;
        Ack0      = 1'b0;
        Ack1      = 1'b0;
        Err       = 1'b0;
        Busy      = (state != IDLE);
`ifdef MULT_ARB_TIMEOUT_EN
        wd_cnt_nx = wd_cnt;
        abort_nx  = abort;
`endif
        case (state)
            IDLE: begin
                if (Req0 || Req1) begin
                    // Pointer only matters when both request; otherwise the lone requester wins.
                    grant1    = Req1 && (!Req0 || ptr);
                    owner_nx  = grant1;
                    mcand_nx  = grant1 ? A1 : A0;
                    mplier_nx = grant1 ? B1 : B0;
                    state_nx  = WAIT_IDLE;
`ifdef MULT_ARB_TIMEOUT_EN
                    abort_nx  = 1'b0;
`endif
                end
            end
            WAIT_IDLE: begin
                if (Idle) begin
                    St       = 1'b1;
                    state_nx = RUN;
`ifdef MULT_ARB_TIMEOUT_EN
                    wd_cnt_nx = '0;
`endif
                end
            end
            RUN: begin
                if (Done) begin
                    result_nx = Produto;
                    state_nx  = ACK;
                end
`ifdef MULT_ARB_TIMEOUT_EN
                else if (wd_cnt == CW'(TIMEOUT - 1)) begin
                    result_nx = '0;
                    abort_nx  = 1'b1;
                    state_nx  = ACK;
                end else begin
                    wd_cnt_nx = wd_cnt + 1'b1;
                end
`endif
            end
            ACK: begin
                Ack0     = !owner;
                Ack1     = owner;
`ifdef MULT_ARB_TIMEOUT_EN
                Err      = abort;
`endif
                ptr_nx   = !owner;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign dbg_state = state;
    assign dbg_ptr   = ptr;

endmodule
